// File: rtl/peripheral_dbg_soc_bb_pkg.sv
// Shared encodings for the MAM "bb" AHB-lite-style bus and the memory responder FSM.
// Contents: HTRANS_*, HSIZE_*, HRESP_* codes and the responder state enum.
package peripheral_dbg_soc_bb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr1,
        StErr2
    } bb_state_e;

endpackage

// File: rtl/peripheral_dbg_soc_bb_mem_responder_if.sv
// Bundle of the bb bus signals between the memory-access initiator (master) and the
// memory responder (slave).
// Master drives: hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock.
// Slave drives:  hrdata, hready, hresp.
interface peripheral_dbg_soc_bb_mem_responder_if #(
    parameter int unsigned XLEN = 16,
    parameter int unsigned AW   = 16
);
    logic            hsel;
    logic [AW-1:0]   haddr;
    logic [XLEN-1:0] hwdata;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic [3:0]      hprot;
    logic [1:0]      htrans;
    logic            hmastlock;
    logic [XLEN-1:0] hrdata;
    logic            hready;
    logic            hresp;

    modport master (
        output hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/peripheral_dbg_soc_bb_mem_array.sv
// DEPTH x XLEN word memory with per-byte-lane write enables and asynchronous read.
// Ports: clk_i clock; we_i per-lane write enable; addr_i word index (shared by read
// and write); wdata_i write data in lane positions; rdata_o full word at addr_i.
// Contents are deliberately not reset.
module peripheral_dbg_soc_bb_mem_array #(
    parameter int unsigned XLEN  = 16,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned SW   = XLEN / 8,
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic [SW-1:0]   we_i,
    input  logic [IW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < SW; i++) begin
            if (we_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/peripheral_dbg_soc_bb_mem_responder.sv
// Slave-side memory responder for the MAM bb bus. Accepts AHB-lite-style transfers,
// inserts WAIT_STATES wait cycles per data phase, performs byte-lane-masked writes,
// returns read data, and answers illegal transfers with a two-cycle ERROR response.
// Ports: clk_i clock; rst_i synchronous active-high reset; bb slave side of the bus
// (address/control/write data in, hrdata/hready/hresp out).
module peripheral_dbg_soc_bb_mem_responder
    import peripheral_dbg_soc_bb_pkg::*;
#(
    parameter int unsigned XLEN        = 16,
    parameter int unsigned AW          = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic clk_i,
    input logic rst_i,
    peripheral_dbg_soc_bb_mem_responder_if.slave bb
);

    localparam int unsigned SW        = XLEN / 8;
    localparam int unsigned LSW       = $clog2(SW);
    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MEM_BYTES = DEPTH * SW;

    bb_state_e       state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic [3:0]      ws_q, ws_d;

    logic            hready;
    logic            hresp;
    logic            accept;
    logic            legal;
    logic [SW-1:0]   lane_en;
    logic [SW-1:0]   mem_we;
    logic [IW-1:0]   word_idx;
    logic [XLEN-1:0] mem_rdata;

    // Ignored bus attributes; SEQ and NONSEQ are handled identically.
    logic unused_bus;
    assign unused_bus = ^{bb.hburst, bb.hprot, bb.hmastlock, bb.htrans[0]};

    // Response outputs are purely a function of the current state.
    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        unique case (state_q)
            StIdle: ;
            StData: hready = (ws_q == 4'd0);
            StErr1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            StErr2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign accept = hready & bb.hsel & bb.htrans[1];

    // Out of range, wider than the bus, or misaligned for its size.
    always_comb begin
        legal = 1'b1;
        if (64'(bb.haddr) >= 64'(MEM_BYTES)) begin
            legal = 1'b0;
        end
        if (bb.hsize > 3'(LSW)) begin
            legal = 1'b0;
        end
        if ((32'(bb.haddr) & ((32'd1 << bb.hsize) - 32'd1)) != 32'd0) begin
            legal = 1'b0;
        end
    end

    // Every cycle that completes a phase (hready high) re-applies the accept rule,
    // which gives back-to-back pipelining out of DATA and ERR2.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        if (hready) begin
            if (accept) begin
                state_d = legal ? StData : StErr1;
                ws_d    = 4'(WAIT_STATES);
            end else begin
                state_d = StIdle;
            end
        end else if (state_q == StData) begin
            ws_d = ws_q - 4'd1;
        end else begin
            state_d = StErr2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ws_q    <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            if (accept) begin
                addr_q  <= bb.haddr;
                size_q  <= bb.hsize;
                write_q <= bb.hwrite;
            end
        end
    end

    // Little-endian lanes: 2^size_q lanes starting at the byte offset within the word.
    always_comb begin
        int unsigned first;
        int unsigned nlanes;
        first  = 32'(addr_q) % SW;
        nlanes = 32'd1 << size_q;
        for (int unsigned i = 0; i < SW; i++) begin
            lane_en[i] = (i >= first) && (i < first + nlanes);
        end
    end

    // Commit only on the completing edge; a reset on that edge discards the write.
    assign mem_we   = (state_q == StData && write_q && hready && !rst_i) ? lane_en : '0;
    assign word_idx = IW'(addr_q >> LSW);

    peripheral_dbg_soc_bb_mem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (bb.hwdata),
        .rdata_o (mem_rdata)
    );

    assign bb.hready = hready;
    assign bb.hresp  = hresp;
    assign bb.hrdata = (state_q == StData && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_peripheral_dbg_soc_bb_mem_responder.sv
// Bench for the bb memory responder: two instances (0 and 3 wait states) share one
// bus driver; sel picks which one sees hsel and whose outputs are observed.
module tb_peripheral_dbg_soc_bb_mem_responder;

    typedef struct packed {
        logic [1:0]  trans;
        logic [15:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [15:0] wdata;
    } beat_t;

    typedef struct packed {
        logic        resp;
        logic [15:0] rdata;
        logic [7:0]  waits;
        logic [15:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        hsel = 1'b0;
    logic [15:0] haddr = 16'h0;
    logic [15:0] hwdata = 16'h0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd1;
    logic [3:0]  hprot = 4'd3;
    logic [1:0]  htrans = 2'd0;
    logic        hmastlock = 1'b0;

    logic        hready;
    logic        hresp;
    logic [15:0] hrdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    beat_t       prog[$];
    exp_t        sb[$];
    logic [15:0] model [2][1024];

    always #5 clk = ~clk;

    peripheral_dbg_soc_bb_mem_responder_if #(.XLEN(16), .AW(16)) bb0 ();
    peripheral_dbg_soc_bb_mem_responder_if #(.XLEN(16), .AW(16)) bb1 ();

    assign bb0.hsel = hsel & ~sel;
    assign bb1.hsel = hsel & sel;
    assign bb0.haddr = haddr;         assign bb1.haddr = haddr;
    assign bb0.hwdata = hwdata;       assign bb1.hwdata = hwdata;
    assign bb0.hwrite = hwrite;       assign bb1.hwrite = hwrite;
    assign bb0.hsize = hsize;         assign bb1.hsize = hsize;
    assign bb0.hburst = hburst;       assign bb1.hburst = hburst;
    assign bb0.hprot = hprot;         assign bb1.hprot = hprot;
    assign bb0.htrans = htrans;       assign bb1.htrans = htrans;
    assign bb0.hmastlock = hmastlock; assign bb1.hmastlock = hmastlock;

    assign hready = sel ? bb1.hready : bb0.hready;
    assign hresp  = sel ? bb1.hresp  : bb0.hresp;
    assign hrdata = sel ? bb1.hrdata : bb0.hrdata;

    peripheral_dbg_soc_bb_mem_responder #(
        .XLEN(16), .AW(16), .DEPTH(1024), .WAIT_STATES(0)
    ) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bb    (bb0)
    );

    peripheral_dbg_soc_bb_mem_responder #(
        .XLEN(16), .AW(16), .DEPTH(1024), .WAIT_STATES(3)
    ) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bb    (bb1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] t, input logic [15:0] a,
                                 input logic [2:0] s, input logic wr, input logic [15:0] d);
        beat_t b;
        b.trans = t;
        b.addr  = a;
        b.size  = s;
        b.write = wr;
        b.wdata = d;
        return b;
    endfunction

    // Expected outcome of an accepted beat; updates the shadow memory for writes.
    function automatic exp_t model_beat(input beat_t b);
        exp_t       e;
        logic [9:0] w;
        logic       legal;
        legal   = (b.addr < 16'h0800) && (b.size <= 3'd1) && !(b.size == 3'd1 && b.addr[0]);
        w       = b.addr[10:1];
        e.resp  = !legal;
        e.waits = legal ? (sel ? 8'd3 : 8'd0) : 8'd1;
        e.wdata = b.wdata;
        e.rdata = 16'h0;
        if (legal && b.write) begin
            if (b.size == 3'd0) begin
                if (b.addr[0]) model[sel][w][15:8] = b.wdata[15:8];
                else           model[sel][w][7:0]  = b.wdata[7:0];
            end else begin
                model[sel][w] = b.wdata;
            end
        end else if (legal) begin
            e.rdata = model[sel][w];
        end
        return e;
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    // Plays prog on the bus: address phase on one negedge, data phase completes when
    // hready is seen high at a later negedge (outputs are stable between edges).
    task automatic run_prog();
        int unsigned low_cnt = 0;
        int          guard = 0;
        beat_t       b;
        exp_t        e;
        while ((prog.size() > 0 || sb.size() > 0) && guard < 500) begin
            @(negedge clk);
            guard++;
            hwdata = (sb.size() > 0) ? sb[0].wdata : 16'h0;
            if (sb.size() == 0) begin
                check_eq("idle_hready", 32'(hready), 32'd1);
                check_eq("idle_hresp", 32'(hresp), 32'd0);
                check_eq("idle_hrdata", 32'(hrdata), 32'd0);
            end else if (!hready) begin
                low_cnt++;
                check_eq("wait_hresp", 32'(hresp), 32'(sb[0].resp));
            end else begin
                e = sb.pop_front();
                check_eq("hrdata", 32'(hrdata), 32'(e.rdata));
                check_eq("hresp", 32'(hresp), 32'(e.resp));
                check_eq("wait_cycles", low_cnt, 32'(e.waits));
                low_cnt = 0;
            end
            if (hready) begin
                if (prog.size() > 0) begin
                    b      = prog.pop_front();
                    hsel   = 1'b1;
                    htrans = b.trans;
                    haddr  = b.addr;
                    hsize  = b.size;
                    hwrite = b.write;
                    if (b.trans[1]) sb.push_back(model_beat(b));
                end else begin
                    drive_idle();
                end
            end
        end
        if (guard >= 500) begin
            check_eq("timeout", 32'd1, 32'd0);
            prog.delete();
            sb.delete();
        end
        drive_idle();
    endtask

    initial begin
        logic [15:0] raddr [6];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_hready0", 32'(bb0.hready), 32'd1);
        check_eq("rst_hresp0", 32'(bb0.hresp), 32'd0);
        check_eq("rst_hrdata0", 32'(bb0.hrdata), 32'd0);
        check_eq("rst_hready1", 32'(bb1.hready), 32'd1);

        // Zero wait states: back-to-back write/read, lane-masked writes.
        sel = 1'b0;
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b1, 16'hBEEF));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b1, 16'h1234));
        prog.push_back(mk(2'd2, 16'h0011, 3'd0, 1'b1, 16'hAA00));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        prog.push_back(mk(2'd2, 16'h0010, 3'd0, 1'b1, 16'h0055));
        prog.push_back(mk(2'd0, 16'h0010, 3'd1, 1'b0, 16'h0));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        run_prog();

        // Illegal transfers: out of range, misaligned, too wide; memory must not change.
        prog.push_back(mk(2'd2, 16'h0800, 3'd1, 1'b0, 16'h0));
        prog.push_back(mk(2'd2, 16'h0011, 3'd1, 1'b1, 16'hFFFF));
        prog.push_back(mk(2'd2, 16'h0010, 3'd2, 1'b1, 16'hFFFF));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        run_prog();

        // Incrementing SEQ burst with a BUSY between beats 2 and 3.
        prog.push_back(mk(2'd2, 16'h0040, 3'd1, 1'b1, 16'h1111));
        prog.push_back(mk(2'd3, 16'h0042, 3'd1, 1'b1, 16'h2222));
        prog.push_back(mk(2'd1, 16'h0044, 3'd1, 1'b1, 16'h0));
        prog.push_back(mk(2'd3, 16'h0044, 3'd1, 1'b1, 16'h3333));
        prog.push_back(mk(2'd3, 16'h0046, 3'd1, 1'b1, 16'h4444));
        for (int i = 0; i < 4; i++) begin
            prog.push_back(mk(2'd2, 16'h0040 + 16'(2 * i), 3'd1, 1'b0, 16'h0));
        end
        run_prog();

        for (int i = 0; i < 6; i++) begin
            raddr[i] = 16'h0100 + 16'(i * 6);
            prog.push_back(mk(2'd2, raddr[i], 3'd1, 1'b1, 16'($urandom)));
        end
        for (int i = 5; i >= 0; i--) begin
            prog.push_back(mk(2'd2, raddr[i], 3'd1, 1'b0, 16'h0));
        end
        run_prog();

        // Three wait states.
        sel = 1'b1;
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b1, 16'h5A5A));
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        prog.push_back(mk(2'd2, 16'h0801, 3'd0, 1'b0, 16'h0));
        run_prog();

        // Reset on the commit edge of a waited write must discard it.
        @(negedge clk);
        hsel = 1'b1; htrans = 2'd2; haddr = 16'h0010; hsize = 3'd1; hwrite = 1'b1;
        @(negedge clk);
        drive_idle();
        hwdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            check_eq("rstw_hready_low", 32'(hready), 32'd0);
            @(negedge clk);
        end
        check_eq("rstw_hready_high", 32'(hready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstw_hready", 32'(hready), 32'd1);
        check_eq("rstw_hresp", 32'(hresp), 32'd0);
        check_eq("rstw_hrdata", 32'(hrdata), 32'd0);
        prog.push_back(mk(2'd2, 16'h0010, 3'd1, 1'b0, 16'h0));
        run_prog();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
